// File: rtl/eq_pipe_pkg.sv
// Shared constants and elaboration-time helpers for the eq_pipe comparator.
// Level sizes/offsets describe the flat node vector holding every stage.
package eq_pipe_pkg;

   localparam int LEAF_W = 3;

   function automatic int ceil_div(input int n, input int d);
      return (n + d - 1) / d;
   endfunction

   function automatic int num_levels(input int width, input int fanin);
      int g;
      int n;
      g = ceil_div(width, LEAF_W);
      n = 0;
      while (g > 1) begin
         g = ceil_div(g, fanin);
         n++;
      end
      return (n < 1) ? 1 : n;
   endfunction

   function automatic int lvl_cnt(input int width, input int fanin, input int lvl);
      int g;
      g = ceil_div(width, LEAF_W);
      for (int i = 0; i < lvl; i++) g = ceil_div(g, fanin);
      return g;
   endfunction

   function automatic int lvl_off(input int width, input int fanin, input int lvl);
      int s;
      s = 0;
      for (int i = 0; i < lvl; i++) s += lvl_cnt(width, fanin, i);
      return s;
   endfunction

endpackage

// File: rtl/eq_mask_3.sv
// 3-bit leaf comparator; with EQ_PIPE_MASK_EN defined cleared mask bits
// are treated as equal, otherwise the mask is ignored.
module eq_mask_3
   import eq_pipe_pkg::*;
#(
   parameter int TARGET_CHIP = 2
) (
   input  logic [LEAF_W-1:0] a,
   input  logic [LEAF_W-1:0] b,
   input  logic [LEAF_W-1:0] mask,
   output logic              eq
);

`ifdef EQ_PIPE_MASK_EN
   if (TARGET_CHIP == 0) begin : g_generic
      assign eq = &(~(a ^ b) | ~mask);
   end else begin : g_lut
      assign eq = ((a ^ b) & mask) == '0;
   end
`else
   logic unused_mask;
   assign unused_mask = ^mask;
   if (TARGET_CHIP == 0) begin : g_generic
      assign eq = &(a ~^ b);
   end else begin : g_lut
      assign eq = (a == b);
   end
`endif

endmodule

// File: rtl/eq_pipe.sv
// Pipelined WIDTH-bit equality compare with global stall, tag sideband and
// saturating match counter. Masking is enabled by defining EQ_PIPE_MASK_EN.
module eq_pipe
   import eq_pipe_pkg::*;
#(
   parameter int TARGET_CHIP = 2,
   parameter int WIDTH       = 72,
   parameter int FANIN       = 6,
   parameter int TAG_W       = 8,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             sclr,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic [WIDTH-1:0] din_a,
   input  logic [WIDTH-1:0] din_b,
   input  logic [WIDTH-1:0] din_mask,
   input  logic [TAG_W-1:0] din_tag,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             dout_match,
   output logic [TAG_W-1:0] dout_tag,
   output logic [CNT_W-1:0] match_cnt
);

   localparam int G   = ceil_div(WIDTH, LEAF_W);
   localparam int N   = num_levels(WIDTH, FANIN);
   localparam int PW  = G * LEAF_W;
   localparam int TOT = lvl_off(WIDTH, FANIN, N + 1);

   logic [PW-1:0]           a_p;
   logic [PW-1:0]           b_p;
   logic [PW-1:0]           m_p;
   logic [G-1:0]            leaf_eq;
   logic [TOT-1:0]          node;
   logic [TOT-1:0]          node_d;
   logic [N:0]              vld;
   logic [N:0][TAG_W-1:0]   tag;
   logic [CNT_W-1:0]        cnt;
   logic                    adv;
   logic                    acc;

   // Padding bits are zero on both operands and masked off, so they match.
   assign a_p = PW'(din_a);
   assign b_p = PW'(din_b);
   assign m_p = PW'(din_mask);

   assign adv       = dout_ready | ~vld[N];
   assign din_ready = adv & ~sclr;
   assign acc       = din_valid & din_ready;

   for (genvar g = 0; g < G; g++) begin : g_leaf
      eq_mask_3 #(
         .TARGET_CHIP(TARGET_CHIP)
      ) u_leaf (
         .a   (a_p[g*LEAF_W +: LEAF_W]),
         .b   (b_p[g*LEAF_W +: LEAF_W]),
         .mask(m_p[g*LEAF_W +: LEAF_W]),
         .eq  (leaf_eq[g])
      );
   end

   assign node_d[G-1:0] = leaf_eq;

   // node holds level 0 (leaves) up to level N (single result bit) back to back.
   for (genvar l = 1; l <= N; l++) begin : g_lvl
      localparam int PO = lvl_off(WIDTH, FANIN, l - 1);
      localparam int PC = lvl_cnt(WIDTH, FANIN, l - 1);
      localparam int CO = lvl_off(WIDTH, FANIN, l);
      for (genvar j = 0; j < lvl_cnt(WIDTH, FANIN, l); j++) begin : g_node
         localparam int LO = PO + j * FANIN;
         localparam int HE = ((j + 1) * FANIN < PC) ? (j + 1) * FANIN : PC;
         localparam int HI = PO + HE - 1;
         assign node_d[CO + j] = &node[HI:LO];
      end
   end

   always_ff @(posedge clk) begin
      if (sclr) begin
         node <= '0;
         vld  <= '0;
         tag  <= '0;
      end else if (adv) begin
         node <= node_d;
         vld  <= {vld[N-1:0], acc};
         tag  <= {tag[N-1:0], din_tag};
      end
   end

   always_ff @(posedge clk) begin
      if (sclr) begin
         cnt <= '0;
      end else if (vld[N] & dout_ready & node[TOT-1] & ~&cnt) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign dout_valid = vld[N];
   assign dout_match = node[TOT-1];
   assign dout_tag   = tag[N];
   assign match_cnt  = cnt;

endmodule

// File: tb/tb_eq_pipe.sv
// Scoreboard bench: WIDTH=72/CNT_W=4 random+directed traffic under
// backpressure, plus a WIDTH=1 instance for padding and latency.
module tb_eq_pipe;

   localparam int W  = 72;
   localparam int TW = 8;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          sclr, din_valid, din_ready;
   logic [W-1:0]  din_a, din_b, din_mask;
   logic [TW-1:0] din_tag, dout_tag;
   logic          dout_valid, dout_ready, dout_match;
   logic [CW-1:0] match_cnt;

   logic          s_sclr, s_din_valid, s_din_ready;
   logic [0:0]    s_a, s_b, s_m, s_tag, s_dout_tag;
   logic          s_dout_valid, s_dout_ready, s_dout_match;
   logic [3:0]    s_cnt;

   eq_pipe #(
      .TARGET_CHIP(2), .WIDTH(W), .FANIN(6), .TAG_W(TW), .CNT_W(CW)
   ) dut (
      .clk(clk), .sclr(sclr),
      .din_valid(din_valid), .din_ready(din_ready),
      .din_a(din_a), .din_b(din_b), .din_mask(din_mask), .din_tag(din_tag),
      .dout_valid(dout_valid), .dout_ready(dout_ready),
      .dout_match(dout_match), .dout_tag(dout_tag), .match_cnt(match_cnt)
   );

   eq_pipe #(
      .TARGET_CHIP(0), .WIDTH(1), .FANIN(6), .TAG_W(1), .CNT_W(4)
   ) dut1 (
      .clk(clk), .sclr(s_sclr),
      .din_valid(s_din_valid), .din_ready(s_din_ready),
      .din_a(s_a), .din_b(s_b), .din_mask(s_m), .din_tag(s_tag),
      .dout_valid(s_dout_valid), .dout_ready(s_dout_ready),
      .dout_match(s_dout_match), .dout_tag(s_dout_tag), .match_cnt(s_cnt)
   );

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic          m;
      logic [TW-1:0] t;
   } exp_t;

   exp_t q[$];
   int   exp_cnt = 0;
   int   rdy_mode = 0;
   logic s_done = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic ref_match(input logic [W-1:0] a, b, m);
`ifdef EQ_PIPE_MASK_EN
      return ((a ^ b) & m) == '0;
`else
      return a == b;
`endif
   endfunction

   function automatic logic [W-1:0] rnd_w();
      return W'({$urandom(), $urandom(), $urandom()});
   endfunction

   task automatic drive_ready();
      case (rdy_mode)
         0:       dout_ready = 1'b1;
         1:       dout_ready = ~dout_ready;
         default: dout_ready = ($urandom_range(0, 9) < 6);
      endcase
   endtask

   task automatic send(input logic [W-1:0] a, b, m, input logic [TW-1:0] t);
      int n;
      exp_t e;
      @(negedge clk);
      din_a = a; din_b = b; din_mask = m; din_tag = t; din_valid = 1'b1;
      drive_ready();
      #1;
      n = 0;
      while (!din_ready && n < 50) begin
         @(negedge clk);
         drive_ready();
         #1;
         n++;
      end
      if (din_ready) begin
         e.m = ref_match(a, b, m);
         e.t = t;
         q.push_back(e);
      end else begin
         checks++;
         failures++;
         $display("FAIL accept_timeout: tag %0h never accepted", t);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         din_valid = 1'b0;
         drive_ready();
      end
   endtask

   task automatic drain();
      int n;
      rdy_mode = 0;
      n = 0;
      while (q.size() > 0 && n < 100) begin
         idle(1);
         n++;
      end
      idle(2);
      chk("drain_empty", 64'(q.size()), 64'd0);
   endtask

   task automatic rnd_beat(input logic [TW-1:0] t);
      logic [W-1:0] a, b, m;
      a = rnd_w();
      b = a;
      if ($urandom_range(0, 1) == 1) begin
         int i;
         i = $urandom_range(0, W - 1);
         b[i] = ~b[i];
      end
      m = '1;
      if ($urandom_range(0, 3) == 0) m = rnd_w();
      send(a, b, m, t);
   endtask

   // Monitor: pops the scoreboard on every transfer, tracks the counter.
   logic          prev_stall = 1'b0;
   logic [TW:0]   prev_out = '0;
   always begin
      exp_t e;
      @(negedge clk);
      #2;
      if (sclr) begin
         q.delete();
         exp_cnt = 0;
         prev_stall = 1'b0;
      end else begin
         chk("match_cnt", 64'(match_cnt), 64'(exp_cnt));
         if (prev_stall) begin
            chk("stall_valid", 64'(dout_valid), 64'd1);
            chk("stall_data", 64'({dout_match, dout_tag}), 64'(prev_out));
         end
         if (dout_valid && dout_ready) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat: tag %0h with empty scoreboard", dout_tag);
            end else begin
               e = q.pop_front();
               chk("dout_match", 64'(dout_match), 64'(e.m));
               chk("dout_tag", 64'(dout_tag), 64'(e.t));
               if (e.m) exp_cnt = (exp_cnt == CMAX) ? CMAX : exp_cnt + 1;
            end
         end
         prev_stall = dout_valid && !dout_ready;
         prev_out = {dout_match, dout_tag};
      end
   end

   function automatic logic s_ref(input logic a, b, m);
`ifdef EQ_PIPE_MASK_EN
      return ((a ^ b) & m) == 1'b0;
`else
      return a == b;
`endif
   endfunction

   int s_exp = 0;

   task automatic s_beat(input logic a, b, m, t);
      int lat;
      @(negedge clk);
      s_a = a; s_b = b; s_m = m; s_tag = t; s_din_valid = 1'b1;
      #1;
      chk("w1_din_ready", 64'(s_din_ready), 64'd1);
      @(negedge clk);
      s_din_valid = 1'b0;
      lat = 1;
      #2;
      while (!s_dout_valid && lat < 10) begin
         @(negedge clk);
         #2;
         lat++;
      end
      chk("w1_latency", 64'(lat), 64'd2);
      chk("w1_match", 64'(s_dout_match), 64'(s_ref(a, b, m)));
      chk("w1_tag", 64'(s_dout_tag), 64'(t));
      if (s_ref(a, b, m)) s_exp++;
   endtask

   initial begin
      s_sclr = 1'b1; s_din_valid = 1'b0; s_dout_ready = 1'b1;
      s_a = '0; s_b = '0; s_m = '0; s_tag = '0;
      repeat (3) @(negedge clk);
      s_sclr = 1'b0;
      s_beat(1'b1, 1'b0, 1'b1, 1'b0);
      s_beat(1'b1, 1'b1, 1'b1, 1'b1);
      s_beat(1'b1, 1'b0, 1'b0, 1'b0);
      s_beat(1'b0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      #2;
      chk("w1_match_cnt", 64'(s_cnt), 64'(s_exp));
      s_done = 1'b1;
   end

   initial begin
      logic [W-1:0] a, b71, ones, m71;
      int lat;
      sclr = 1'b1; din_valid = 1'b0; dout_ready = 1'b1;
      din_a = '0; din_b = '0; din_mask = '0; din_tag = '0;
      ones = '1;
      b71 = '0;
      b71[W-1] = 1'b1;
      m71 = ones ^ b71;

      repeat (2) @(negedge clk);
      #1;
      chk("rst_din_ready", 64'(din_ready), 64'd0);
      @(negedge clk);
      sclr = 1'b0;
      #2;
      chk("rst_dout_valid", 64'(dout_valid), 64'd0);
      chk("rst_dout_match", 64'(dout_match), 64'd0);
      chk("rst_dout_tag", 64'(dout_tag), 64'd0);
      chk("rst_match_cnt", 64'(match_cnt), 64'd0);
      chk("rst_din_ready_after", 64'(din_ready), 64'd1);

      // Latency of an isolated beat through the 72-bit pipe.
      a = rnd_w();
      send(a, a, ones, 8'hA0);
      @(negedge clk);
      din_valid = 1'b0;
      lat = 1;
      #2;
      while (!dout_valid && lat < 10) begin
         @(negedge clk);
         #2;
         lat++;
      end
      chk("w72_latency", 64'(lat), 64'd3);
      drain();

      a = rnd_w();
      send(a, a ^ b71, ones, 8'hB1);
      send(a, a ^ b71, m71, 8'hB2);
      send(a, a, '0, 8'hB3);
      drain();

      rdy_mode = 1;
      for (int t = 0; t < 16; t++) begin
         a = rnd_w();
         send(a, a, ones, 8'(t));
      end
      idle(4);
      drain();

      rdy_mode = 2;
      for (int t = 0; t < 200; t++) begin
         rnd_beat(8'(t));
         if ($urandom_range(0, 4) == 0) idle(1);
      end
      drain();

      // Reset with two beats still in flight.
      send(rnd_w(), rnd_w(), ones, 8'hC1);
      send(a, a, ones, 8'hC2);
      @(negedge clk);
      sclr = 1'b1; dout_ready = 1'b0; din_valid = 1'b1;
      din_a = a; din_b = a; din_tag = 8'hC3;
      #1;
      chk("sclr_din_ready", 64'(din_ready), 64'd0);
      @(negedge clk);
      sclr = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
      #1;
      chk("sclr_dout_valid", 64'(dout_valid), 64'd0);
      chk("sclr_match_cnt", 64'(match_cnt), 64'd0);
      idle(10);

      rdy_mode = 2;
      for (int t = 0; t < 20; t++) rnd_beat(8'(t + 8'h40));
      drain();

      rdy_mode = 2;
      for (int t = 0; t < 20; t++) begin
         a = rnd_w();
         send(a, a, ones, 8'(t + 8'h80));
      end
      drain();
      chk("cnt_saturated", 64'(match_cnt), 64'(CMAX));

      lat = 0;
      while (!s_done && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("w1_done", 64'(s_done), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
